// File: rtl/fft_ram_stream_reader.sv
// fft_ram_stream_reader: reads one 2^LOG2_N-sample frame from a 1-cycle SRAM port
// (natural or bit-reversed order) and streams re/im halves with first/last markers.
module fft_ram_stream_reader #(
    parameter int SWIDTH = 16,
    parameter int LOG2_N = 7,
    parameter int AWIDTH = 7
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  en_in,
    input  logic                  bitrev_in,
    input  logic [AWIDTH-1:0]     base_addr_in,
    output logic [AWIDTH-1:0]     ram_addr,
    output logic                  read_en,
    input  logic [2*SWIDTH-1:0]   ram_data,
    output logic [SWIDTH-1:0]     re_data,
    output logic [SWIDTH-1:0]     im_data,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  data_first,
    output logic                  data_last,
    output logic                  busy,
    output logic                  done
);
    localparam int EW = 2*SWIDTH + 2;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t              state_q;
    logic [LOG2_N-1:0]   rd_cnt_q;
    logic [LOG2_N-1:0]   rev_cnt;
    logic                bitrev_q;
    logic [AWIDTH-1:0]   base_q;
    logic [AWIDTH-1:0]   addr_q;
    logic [AWIDTH-1:0]   next_addr;
    logic                inflight_q;
    logic [1:0]          tag_q;
    logic                busy_q;
    logic                done_q;
    logic [EW-1:0]       fifo_q [2];
    logic                wr_ptr_q;
    logic                rd_ptr_q;
    logic [1:0]          count_q;
    logic [1:0]          count_d;
    logic                push;
    logic                pop;
    logic                last_issue;
    logic                drain_exit;
    logic [EW-1:0]       head;

    always_comb begin
        rev_cnt = '0;
        for (int i = 0; i < LOG2_N; i++) rev_cnt[i] = rd_cnt_q[LOG2_N-1-i];
    end

    assign next_addr  = base_q + AWIDTH'(bitrev_q ? rev_cnt : rd_cnt_q);
    assign data_valid = count_q != 2'd0;
    assign pop        = data_valid && data_ready;
    assign push       = inflight_q;
    // Count buffered plus in-flight samples so a returning read always has a slot.
    assign read_en    = (state_q == READ) &&
                        (({1'b0, count_q} + 3'(inflight_q) - 3'(pop)) < 3'd2);
    assign ram_addr   = read_en ? next_addr : addr_q;
    assign last_issue = read_en && (&rd_cnt_q);
    assign count_d    = count_q + 2'(push) - 2'(pop);
    assign drain_exit = (state_q == DRAIN) && !inflight_q && (count_d == 2'd0);
    assign head       = fifo_q[rd_ptr_q];
    assign {re_data, im_data, data_first, data_last} = data_valid ? head : '0;
    assign busy       = busy_q;
    assign done       = done_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            rd_cnt_q   <= '0;
            bitrev_q   <= 1'b0;
            base_q     <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            done_q     <= drain_exit;
            inflight_q <= read_en;
            count_q    <= count_d;
            if (read_en) begin
                tag_q    <= {rd_cnt_q == '0, &rd_cnt_q};
                addr_q   <= next_addr;
                rd_cnt_q <= rd_cnt_q + 1'b1;
            end
            if (push) begin
                fifo_q[wr_ptr_q] <= {ram_data, tag_q};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case (state_q)
                IDLE: if (en_in) begin
                    state_q  <= READ;
                    bitrev_q <= bitrev_in;
                    base_q   <= base_addr_in;
                    rd_cnt_q <= '0;
                    busy_q   <= 1'b1;
                end
                READ: if (last_issue) state_q <= DRAIN;
                DRAIN: if (drain_exit) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
